// File: rtl/instruction_fetch.sv
// Fetch stage of the multicycle MIPS core: reads the word at pc over an Avalon-style bus,
// latches it into the instruction register and splits it into decode fields.
// Define IFETCH_TIMEOUT_EN to fault a fetch that waits more than TIMEOUT_CYCLES cycles.
module instruction_fetch #(
    parameter logic [31:0] HALT_ADDR      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  state,
    input  logic [31:0] pc,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic [3:0]  mem_byteenable,
    output logic        stall,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs_idx,
    output logic [4:0]  rt_idx,
    output logic [4:0]  rd_idx,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] I_immediate,
    output logic [25:0] J_immediate,
    output logic        halted,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDone  = 2'd1,
        StHalt  = 2'd2,
        StFault = 2'd3
    } fsm_e;

    localparam longint unsigned CntMax = (64'd1 << CNT_W) - 64'd1;

    if (CNT_W < 1 || CNT_W > 32 || CntMax < 64'(TIMEOUT_CYCLES)) begin : g_bad_cfg
        $error("instruction_fetch: CNT_W too small for TIMEOUT_CYCLES");
    end

    fsm_e        fsm_q, fsm_d;
    logic [31:0] instr_q, instr_d;
    logic        fetch;
    logic        rd_req;
    logic        stall_raw;
    logic        timeout;

`ifdef IFETCH_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts only cycles spent waiting on an issued read; anything else clears it.
    always_comb begin
        cnt_d = '0;
        if (rd_req && mem_waitrequest) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
    assign timeout = 1'b0;
`endif

    assign fetch = (state == 2'd0);

    always_comb begin
        fsm_d     = fsm_q;
        instr_d   = instr_q;
        rd_req    = 1'b0;
        stall_raw = 1'b0;
        case (fsm_q)
            StIdle: begin
                if (fetch) begin
                    if (pc == HALT_ADDR) begin
                        fsm_d     = StHalt;
                        stall_raw = 1'b1;
                    end else if (pc[1:0] != 2'b00) begin
                        fsm_d     = StFault;
                        stall_raw = 1'b1;
                    end else begin
                        rd_req = 1'b1;
                        if (!mem_waitrequest) begin
                            // Acceptance beats a timeout reached in the same cycle.
                            instr_d = mem_readdata;
                            fsm_d   = StDone;
                        end else begin
                            stall_raw = 1'b1;
                            if (timeout) begin
                                fsm_d = StFault;
                            end
                        end
                    end
                end
            end
            StDone: begin
                if (!fetch) begin
                    fsm_d = StIdle;
                end
            end
            StHalt, StFault: begin
                stall_raw = fetch;
            end
            default: begin
                fsm_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q   <= StIdle;
            instr_q <= 32'h0000_0000;
        end else begin
            fsm_q   <= fsm_d;
            instr_q <= instr_d;
        end
    end

    // Gated by rst so an in-flight read is withdrawn the moment reset asserts.
    assign mem_read       = rd_req & rst;
    assign stall          = stall_raw & rst;
    assign mem_address    = pc;
    assign mem_byteenable = 4'b1111;

    assign halted      = (fsm_q == StHalt);
    assign fetch_fault = (fsm_q == StFault);

    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign rs_idx      = instr_q[25:21];
    assign rt_idx      = instr_q[20:16];
    assign rd_idx      = instr_q[15:11];
    assign shamt       = instr_q[10:6];
    assign funct       = instr_q[5:0];
    assign I_immediate = instr_q[15:0];
    assign J_immediate = instr_q[25:0];

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the PC/next-instruction unit in the multicycle MIPS core.
- During the FETCH phase (state==0) it reads the word at pc from the instruction memory over an Avalon-style read bus with waitrequest, latches it into the instruction register and drives stall back to the PC unit until the word arrives.
- It also splits the instruction into decode fields: I/J immediates for the PC unit, register indices for the register file.
- It detects halt (fetch from HALT_ADDR) and fetch faults.

Parameters:
- HALT_ADDR, 32'h00000000, fetch address that halts the core instead of reading memory.
- TIMEOUT_CYCLES, 255, maximum waitrequest cycles per fetch; used only with IFETCH_TIMEOUT_EN.
- CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock, all registers on posedge.
- rst  in  1  asynchronous, active-low reset.
- state  in  2  phase from PC unit: 0 FETCH, 1 EXEC1, 2 EXEC2; 3 is treated as not-FETCH.
- pc  in  32  current PC from PC unit.
- mem_waitrequest  in  1  instruction memory not ready.
- mem_readdata  in  32  instruction memory read data.
- mem_address  out  32  read address; equals pc.
- mem_read  out  1  read request.
- mem_byteenable  out  4  constant 4'b1111.
- stall  out  1  holds PC unit state machine.
- instr  out  32  instruction register.
- opcode  out  6  instr[31:26].
- rs_idx  out  5  instr[25:21].
- rt_idx  out  5  instr[20:16].
- rd_idx  out  5  instr[15:11].
- shamt  out  5  instr[10:6].
- funct  out  6  instr[5:0].
- I_immediate  out  16  instr[15:0].
- J_immediate  out  26  instr[25:0].
- halted  out  1  sticky; core has fetched HALT_ADDR.
- fetch_fault  out  1  sticky; misaligned fetch or timeout.

Behaviour:
- FSM states:
  - F_IDLE: waiting for, or serving, a fetch.
  - F_DONE: word latched, waiting for state to leave 0.
  - F_HALT: sticky halt.
  - F_FAULT: sticky fault.
- Reset (rst==0, asynchronous):
  - fsm=F_IDLE, instr=32'h0 (NOP), halted=0, fetch_fault=0, counter=0.
  - mem_read=0 and stall=0 immediately, including when reset lands mid-transaction.
- F_IDLE with state==0:
  - pc==HALT_ADDR: next fsm=F_HALT. mem_read=0, stall=1.
  - else pc[1:0]!=0: next fsm=F_FAULT. mem_read=0, stall=1.
  - else: mem_read=1, mem_address=pc.
- Read handshake:
  - mem_read and mem_address are held stable while mem_waitrequest==1.
  - The word is accepted on the posedge where mem_read==1 and mem_waitrequest==0. At that edge instr<=mem_readdata and fsm<=F_DONE.
- stall (combinational) = (state==0) and not (mem_read and not mem_waitrequest), in F_IDLE only.
  - With zero-wait memory, stall is never asserted, so FETCH lasts 1 cycle.
  - With N wait cycles, stall is high for N cycles.
- F_DONE:
  - mem_read=0, stall=0.
  - Returns to F_IDLE on the first cycle with state!=0.
  - If state stays 0 (PC unit externally held), no re-issue occurs.
- instr is held unchanged through EXEC1/EXEC2. Decode outputs are pure slices of instr (registered source, no extra latency).
- F_HALT and F_FAULT:
  - Exit only via reset.
  - mem_read=0; stall=1 whenever state==0.
  - halted=1 in F_HALT; fetch_fault=1 in F_FAULT.
- mem_readdata is ignored whenever mem_read==0.
- Simultaneous acceptance and state change: acceptance takes priority; instr is captured.

Optional Feature:
- IFETCH_TIMEOUT_EN defined:
  - A CNT_W-bit counter increments each cycle with mem_read==1 and mem_waitrequest==1, and clears on acceptance or on leaving F_IDLE.
  - When the counter reaches TIMEOUT_CYCLES while waitrequest is still high, the next edge enters F_FAULT: mem_read drops and fetch_fault=1.
  - Acceptance in the same cycle the limit is reached wins over the fault.
- IFETCH_TIMEOUT_EN undefined:
  - No counter exists; the block waits indefinitely on waitrequest.
  - TIMEOUT_CYCLES and CNT_W are unused.

Test Plan:
- Zero-wait read: pc=32'hBFC00000, state=0, waitrequest=0, readdata=32'h24020005 → mem_read=1 and stall=0 in the same cycle; after the edge instr=32'h24020005, opcode=6'h09, rt_idx=2, I_immediate=16'h0005.
- Three wait cycles: waitrequest=1 for 3 cycles then 0, readdata=32'h0800000C → stall=1 for exactly 3 cycles with mem_address stable; instr=32'h0800000C and J_immediate=26'h000000C after acceptance.
- Halt: PC unit jumps to 32'h0 and state returns to 0 → mem_read stays 0, halted=1 on the next edge, stall=1 on every subsequent FETCH.
- Misaligned: pc=32'hBFC00002 in FETCH → no read issued, fetch_fault=1, stall=1; rst low clears fetch_fault, instr=0, stall=0.
- Reset mid-read: rst driven low while mem_read=1 and waitrequest=1 → mem_read=0 with no clock edge needed; after release, a fresh fetch of pc is issued.
- Timeout with IFETCH_TIMEOUT_EN and TIMEOUT_CYCLES=4: waitrequest stuck at 1 → mem_read high for 5 cycles, then fetch_fault=1 and mem_read=0. Without the macro, mem_read remains 1 and no fault is raised.
